// File: rtl/audio_play_ctrl.sv
// audio_play_ctrl: holds the DAI in reset until the codec is configured, turns
// debounced keys into transport commands and walks one of four ROM clips.
module audio_play_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CLIP_LEN        = 65536,
    parameter int ADDR_W          = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cfg_status,
    input  logic [2:0]        key_n,
    input  logic              loop_en,
    input  logic              sample_req,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_rd,
    output logic              dai_reset,
    output logic [1:0]        clip_sel,
    output logic [3:0]        led
);
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LEN      = ADDR_W'(CLIP_LEN);
    localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(CLIP_LEN - 1);

    typedef enum logic [1:0] {
        S_WAIT_CFG,
        S_IDLE,
        S_PLAY,
        S_PAUSE
    } state_t;

    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_key_db;
    logic [2:0]        r_key_ev;
    logic [CNT_W-1:0]  r_db_cnt [3];

    state_t            r_state;
    logic [ADDR_W-1:0] r_rom_address;
    logic              r_rom_rd;
    logic              r_dai_reset;
    logic [1:0]        r_clip_sel;
    logic [3:0]        r_led;

    logic              w_cfg_ok;
    logic              w_ev_stop;
    logic              w_ev_pp;
    logic              w_ev_next;
    logic              w_at_end;
    logic [1:0]        w_clip_nx;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_base_nx;
    logic [ADDR_W-1:0] w_addr_adv;

    // Counter runs only while the synchronized level differs from the
    // accepted one, so any bounce back restarts the stability window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_key_db <= '1;
            r_key_ev <= '0;
            for (int k = 0; k < 3; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 3; k++) begin
                r_key_ev[k] <= 1'b0;
                if (r_sync2[k] == r_key_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == CNT_MAX) begin
                    r_db_cnt[k] <= '0;
                    r_key_db[k] <= r_sync2[k];
                    r_key_ev[k] <= ~r_sync2[k];
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign w_cfg_ok   = (cfg_status == 4'hA);
    assign w_ev_stop  = r_key_ev[1];
    assign w_ev_pp    = r_key_ev[0] & ~r_key_ev[1];
    assign w_ev_next  = r_key_ev[2] & ~r_key_ev[1] & ~r_key_ev[0];
    assign w_clip_nx  = r_clip_sel + 2'd1;
    assign w_base     = ADDR_W'(r_clip_sel) * LEN;
    assign w_base_nx  = ADDR_W'(w_clip_nx) * LEN;
    assign w_at_end   = ((r_rom_address - w_base) == LAST_OFS);
    assign w_addr_adv = w_at_end ? w_base : r_rom_address + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_WAIT_CFG;
            r_rom_address <= '0;
            r_rom_rd      <= 1'b0;
            r_dai_reset   <= 1'b1;
            r_clip_sel    <= 2'd0;
            r_led         <= 4'd0;
        end else begin
            r_rom_rd <= 1'b0;
            if (r_state != S_WAIT_CFG && !w_cfg_ok) begin
                r_state       <= S_WAIT_CFG;
                r_rom_address <= w_base;
                r_dai_reset   <= 1'b1;
                r_led         <= {r_clip_sel, 2'b00};
            end else begin
                unique case (r_state)
                    S_WAIT_CFG: begin
                        r_rom_address <= w_base;
                        r_dai_reset   <= 1'b1;
                        r_led         <= {r_clip_sel, 2'b00};
                        if (w_cfg_ok) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (w_ev_pp) begin
                            r_state     <= S_PLAY;
                            r_dai_reset <= 1'b0;
                            r_led       <= {r_clip_sel, 2'b01};
                        end else if (w_ev_next) begin
                            r_clip_sel    <= w_clip_nx;
                            r_rom_address <= w_base_nx;
                            r_led         <= {w_clip_nx, 2'b00};
                        end
                    end
                    S_PLAY: begin
                        if (w_ev_stop) begin
                            r_state       <= S_IDLE;
                            r_rom_address <= w_base;
                            r_dai_reset   <= 1'b1;
                            r_led         <= {r_clip_sel, 2'b00};
                        end else if (w_ev_pp) begin
                            r_state     <= S_PAUSE;
                            r_dai_reset <= 1'b1;
                            r_led       <= {r_clip_sel, 2'b10};
                            if (r_rom_rd) begin
                                r_rom_address <= w_addr_adv;
                            end
                        end else if (w_ev_next) begin
                            r_clip_sel    <= w_clip_nx;
                            r_rom_address <= w_base_nx;
                            r_rom_rd      <= sample_req;
                            r_led         <= {w_clip_nx, 2'b01};
                        end else begin
                            r_rom_rd <= sample_req;
                            if (r_rom_rd) begin
                                r_rom_address <= w_addr_adv;
                                if (w_at_end && !loop_en) begin
                                    r_state     <= S_IDLE;
                                    r_rom_rd    <= 1'b0;
                                    r_dai_reset <= 1'b1;
                                    r_led       <= {r_clip_sel, 2'b00};
                                end
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (w_ev_stop) begin
                            r_state       <= S_IDLE;
                            r_rom_address <= w_base;
                            r_led         <= {r_clip_sel, 2'b00};
                        end else if (w_ev_pp) begin
                            r_state     <= S_PLAY;
                            r_dai_reset <= 1'b0;
                            r_led       <= {r_clip_sel, 2'b01};
                        end else if (w_ev_next) begin
                            r_clip_sel    <= w_clip_nx;
                            r_rom_address <= w_base_nx;
                            r_led         <= {w_clip_nx, 2'b10};
                        end
                    end
                    default: begin
                        r_state <= S_WAIT_CFG;
                    end
                endcase
            end
        end
    end

    assign rom_address = r_rom_address;
    assign rom_rd      = r_rom_rd;
    assign dai_reset   = r_dai_reset;
    assign clip_sel    = r_clip_sel;
    assign led         = r_led;

endmodule
